// File: rtl/dirc_controller.sv
// Snake direction front end: synchronises and debounces push-buttons, filters turns, queues them, commits one per tick.
// Optional pause button and state enabled by defining DIRC_PAUSE_EN.
module dirc_controller #(
  parameter logic [19:0] DB_CYCLES = 20'd1000000,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       tick,
`ifdef DIRC_PAUSE_EN
  input  logic       btn_pause,
  output logic       paused,
`endif
  output logic [1:0] dirc,
  output logic       moving,
  output logic [2:0] q_count
);

`ifdef DIRC_PAUSE_EN
  localparam int unsigned NB = 5;
`else
  localparam int unsigned NB = 4;
`endif

  localparam logic [1:0] PMAX = 2'(QDEPTH - 1);
  localparam logic [2:0] QD   = 3'(QDEPTH);

  localparam logic [1:0] D_LEFT  = 2'b00;
  localparam logic [1:0] D_RIGHT = 2'b01;
  localparam logic [1:0] D_UP    = 2'b10;
  localparam logic [1:0] D_DOWN  = 2'b11;

`ifdef DIRC_PAUSE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RUN} state_t;
`endif

  state_t state;

  logic [NB-1:0] raw;
  logic [NB-1:0] s1, s2, db, arm, press;
  logic [19:0]   cnt [NB];

`ifdef DIRC_PAUSE_EN
  assign raw = {btn_pause, btn_down, btn_up, btn_right, btn_left};
`else
  assign raw = {btn_down, btn_up, btn_right, btn_left};
`endif

  // Synchronisers reset to "pressed" and a button stays disarmed until it is
  // seen released, so a button held through reset cannot produce a press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1    <= '1;
      s2    <= '1;
      db    <= '0;
      arm   <= '0;
      press <= '0;
      for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      arm <= arm | ~s2;
      for (int unsigned i = 0; i < NB; i++) begin
        press[i] <= 1'b0;
        if (arm[i] && (s2[i] != db[i])) begin
          if (cnt[i] == DB_CYCLES - 20'd1) begin
            db[i]    <= s2[i];
            cnt[i]   <= '0;
            press[i] <= s2[i];
          end else begin
            cnt[i] <= cnt[i] + 20'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  logic       has_press;
  logic [1:0] pdir;

  always_comb begin
    has_press = 1'b1;
    pdir      = D_LEFT;
    if (press[2])      pdir = D_UP;
    else if (press[3]) pdir = D_DOWN;
    else if (press[0]) pdir = D_LEFT;
    else if (press[1]) pdir = D_RIGHT;
    else               has_press = 1'b0;
  end

  logic [1:0] qmem [4];
  logic [1:0] head, tail, tail_dir;
  logic [1:0] ref_dir;
  logic       active, full, pop, push, rev_ok, pause_press;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == PMAX) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    ref_dir = (q_count != 3'd0) ? tail_dir : dirc;
    full    = (q_count == QD);
`ifdef DIRC_PAUSE_EN
    active      = (state != ST_PAUSE);
    pause_press = press[4];
`else
    active      = 1'b1;
    pause_press = 1'b0;
`endif
    pop    = tick && (q_count != 3'd0) && active;
    rev_ok = (state == ST_IDLE) || (pdir != (ref_dir ^ 2'b01));
    // A full queue still accepts when the head is popped on the same edge.
    push   = has_press && active && (pdir != ref_dir) && rev_ok && (!full || pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      dirc     <= D_RIGHT;
      moving   <= 1'b0;
      q_count  <= '0;
      head     <= '0;
      tail     <= '0;
      tail_dir <= '0;
      for (int unsigned i = 0; i < 4; i++) qmem[i] <= '0;
`ifdef DIRC_PAUSE_EN
      paused   <= 1'b0;
`endif
    end else begin
      if (push) begin
        qmem[tail] <= pdir;
        tail       <= nxt(tail);
        tail_dir   <= pdir;
      end
      if (pop) begin
        dirc <= qmem[head];
        head <= nxt(head);
      end
      case ({push, pop})
        2'b10:   q_count <= q_count + 3'd1;
        2'b01:   q_count <= q_count - 3'd1;
        default: q_count <= q_count;
      endcase

      case (state)
        ST_IDLE: begin
          if (pop) begin
            moving <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause_press) begin
            state <= state_t'(2'd2);
`ifdef DIRC_PAUSE_EN
            paused <= 1'b1;
`endif
          end
        end
        default: begin
          if (pause_press) begin
            state <= ST_RUN;
`ifdef DIRC_PAUSE_EN
            paused <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dirc_controller.sv
// Scoreboard bench for dirc_controller with DB_CYCLES=4, QDEPTH=2.
module tb_dirc_controller;
  logic       clk = 1'b0;
  logic       rstn, btn_left, btn_right, btn_up, btn_down, tick;
  logic [1:0] dirc;
  logic       moving;
  logic [2:0] q_count;
`ifdef DIRC_PAUSE_EN
  logic       btn_pause, paused;
`endif

  always #5 clk = ~clk;

  dirc_controller #(.DB_CYCLES(20'd4), .QDEPTH(2)) dut (
    .clk(clk), .rstn(rstn),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .tick(tick),
`ifdef DIRC_PAUSE_EN
    .btn_pause(btn_pause), .paused(paused),
`endif
    .dirc(dirc), .moving(moving), .q_count(q_count)
  );

  int total = 0;
  int bad   = 0;

  logic [1:0] mq[$];
  logic [1:0] sb[$];
  logic [1:0] mdirc;
  bit         mmoving, mpaused;
  int         mstate;   // 0 idle, 1 run, 2 pause

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    mdirc   = 2'b01;
    mmoving = 1'b0;
    mpaused = 1'b0;
    mstate  = 0;
  endtask

  // Reference behaviour for one clock edge; popped heads go to the scoreboard.
  task automatic model_step(input logic [4:0] m, input bit tk);
    logic [1:0] p, r;
    bit hp, pop, acc;
    int pre;
    pre = mstate;
    hp  = 1'b1;
    if (m[2])      p = 2'b10;
    else if (m[3]) p = 2'b11;
    else if (m[0]) p = 2'b00;
    else if (m[1]) p = 2'b01;
    else begin hp = 1'b0; p = 2'b00; end
    r   = (mq.size() > 0) ? mq[$] : mdirc;
    pop = tk && (mq.size() > 0) && (pre != 2);
    acc = hp && (pre != 2) && (p != r) && (pre == 0 || p != (r ^ 2'b01)) && (mq.size() < 2 || pop);
    if (pop) begin
      mdirc   = mq.pop_front();
      sb.push_back(mdirc);
      mmoving = 1'b1;
      if (pre == 0) mstate = 1;
    end
    if (m[4]) begin
      if (pre == 1) begin mstate = 2; mpaused = 1'b1; end
      else if (pre == 2) begin mstate = 1; mpaused = 1'b0; end
    end
    if (acc) mq.push_back(p);
  endtask

  task automatic drain();
    if (sb.size() > 0) chk("dirc_sb", 32'(dirc), 32'(sb.pop_front()));
    else               chk("dirc_hold", 32'(dirc), 32'(mdirc));
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_qcnt"}, 32'(q_count), 32'(mq.size()));
    chk({tag, "_moving"}, 32'(moving), 32'(mmoving));
`ifdef DIRC_PAUSE_EN
    chk({tag, "_paused"}, 32'(paused), 32'(mpaused));
`endif
  endtask

  task automatic drive_btn(input logic [4:0] m);
    btn_left  = m[0];
    btn_right = m[1];
    btn_up    = m[2];
    btn_down  = m[3];
`ifdef DIRC_PAUSE_EN
    btn_pause = m[4];
`endif
  endtask

  // Press event appears 6 edges after the raw edge and is acted on at the 7th.
  task automatic press_mask(input logic [4:0] m, input bit tk);
    drive_btn(m);
    step(6);
    chk("lat_pre_qcnt", 32'(q_count), 32'(mq.size()));
    if (tk) tick = 1'b1;
    model_step(m, tk);
    step(1);
    tick = 1'b0;
    drain();
    check_state("press");
    drive_btn(5'b0);
    step(7);
    chk("release_qcnt", 32'(q_count), 32'(mq.size()));
  endtask

  task automatic do_tick();
    tick = 1'b1;
    model_step(5'b0, 1'b1);
    step(1);
    tick = 1'b0;
    drain();
    check_state("tick");
  endtask

  initial begin
    rstn = 1'b0;
    tick = 1'b0;
    drive_btn(5'b0);
    model_reset();
    step(3);
    chk("rst_dirc", 32'(dirc), 32'h1);
    chk("rst_moving", 32'(moving), 32'h0);
    chk("rst_qcnt", 32'(q_count), 32'h0);
    rstn = 1'b1;
    step(4);

    // first press from IDLE, then commit
    press_mask(5'b00100, 1'b0);
    chk("A_q1", 32'(q_count), 32'h1);
    do_tick();
    chk("A_dirc", 32'(dirc), 32'h2);
    chk("A_moving", 32'(moving), 32'h1);
    chk("A_q0", 32'(q_count), 32'h0);

    // reversal rejected in RUN
    press_mask(5'b00010, 1'b0);
    do_tick();
    chk("B_dirc_right", 32'(dirc), 32'h1);
    press_mask(5'b00001, 1'b0);
    chk("B_rev_q0", 32'(q_count), 32'h0);
    do_tick();
    chk("B_hold", 32'(dirc), 32'h1);

    // two queued turns
    press_mask(5'b00100, 1'b0);
    press_mask(5'b00001, 1'b0);
    chk("C_q2", 32'(q_count), 32'h2);
    do_tick();
    chk("C_up", 32'(dirc), 32'h2);
    do_tick();
    chk("C_left", 32'(dirc), 32'h0);

    // full queue: drop, then accept alongside a pop
    press_mask(5'b00100, 1'b0);
    do_tick();
    press_mask(5'b00010, 1'b0);
    do_tick();
    chk("D_dirc_right", 32'(dirc), 32'h1);
    press_mask(5'b00100, 1'b0);
    press_mask(5'b00001, 1'b0);
    press_mask(5'b01000, 1'b0);
    chk("D_full_drop", 32'(q_count), 32'h2);
    press_mask(5'b01000, 1'b1);
    chk("D_pushpop_dirc", 32'(dirc), 32'h2);
    chk("D_pushpop_q", 32'(q_count), 32'h2);
    do_tick();
    chk("D_left", 32'(dirc), 32'h0);
    do_tick();
    chk("D_tail_down", 32'(dirc), 32'h3);
    do_tick();

    // glitch shorter than the debounce window
    btn_right = 1'b1;
    step(3);
    btn_right = 1'b0;
    step(8);
    chk("E_glitch", 32'(q_count), 32'h0);
    press_mask(5'b00001, 1'b0);
    press_mask(5'b00100, 1'b0);
    chk("E_q2", 32'(q_count), 32'h2);

    // asynchronous reset, with a button held through it
    #2 rstn = 1'b0;
    btn_up = 1'b1;
    #1;
    chk("E_arst_dirc", 32'(dirc), 32'h1);
    chk("E_arst_moving", 32'(moving), 32'h0);
    chk("E_arst_qcnt", 32'(q_count), 32'h0);
    model_reset();
    step(2);
    rstn = 1'b1;
    step(20);
    chk("E_held_noevt", 32'(q_count), 32'h0);
    btn_up = 1'b0;
    step(8);

    // IDLE: empty tick ignored, reversal allowed for the first press
    do_tick();
    chk("F_idle_moving", 32'(moving), 32'h0);
`ifdef DIRC_PAUSE_EN
    press_mask(5'b10000, 1'b0);
    chk("F_idle_pause", 32'(paused), 32'h0);
`endif
    press_mask(5'b00001, 1'b0);
    chk("F_idle_rev_q1", 32'(q_count), 32'h1);
    do_tick();
    chk("F_dirc_left", 32'(dirc), 32'h0);

    // simultaneous presses: priority up > down > left > right
    press_mask(5'b00101, 1'b0);
    do_tick();
    chk("G_prio_up", 32'(dirc), 32'h2);
    press_mask(5'b01010, 1'b0);
    chk("G_prio_down_rej", 32'(q_count), 32'h0);

`ifdef DIRC_PAUSE_EN
    press_mask(5'b00010, 1'b0);
    do_tick();
    press_mask(5'b00100, 1'b0);
    press_mask(5'b10000, 1'b0);
    chk("H_paused", 32'(paused), 32'h1);
    for (int k = 0; k < 3; k++) do_tick();
    chk("H_dirc_hold", 32'(dirc), 32'h1);
    chk("H_q1", 32'(q_count), 32'h1);
    press_mask(5'b00001, 1'b0);
    chk("H_drop_in_pause", 32'(q_count), 32'h1);
    press_mask(5'b10000, 1'b0);
    chk("H_unpaused", 32'(paused), 32'h0);
    do_tick();
    chk("H_dirc_up", 32'(dirc), 32'h2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/dirc_controller.md
Name: dirc_controller

Overview:
- Upstream stage of the snake direction updater: turns four raw push-buttons into the 2-bit direction code consumed at each game step.
- Synchronises and debounces the buttons, detects presses, and rejects reversals and repeats.
- Buffers up to QDEPTH pending turns and commits exactly one per game tick.
- Direction code: 00 left (x-1), 01 right (x+1), 10 up (y-1), 11 down (y+1); reverse of d is d^2'b01.

Parameters:
- DB_CYCLES, 20'd1000000, clock cycles a synchronised button level must stay stable before it is accepted (≥2).
- QDEPTH, 2, pending-turn queue depth (1..4).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- btn_left  input  1  raw button, active-high, asynchronous.
- btn_right  input  1  raw button, active-high, asynchronous.
- btn_up  input  1  raw button, active-high, asynchronous.
- btn_down  input  1  raw button, active-high, asynchronous.
- tick  input  1  one-cycle game-step strobe from the step timer.
- dirc  output  2  committed direction, fed to the updater.
- moving  output  1  high once the first accepted press has been committed.
- q_count  output  3  pending entries in the queue (debug).

Behaviour:
- Reset (rstn low, async): dirc=2'b01, moving=0, q_count=0, queue cleared, debouncers cleared to "released", FSM=IDLE.
- Input path per button: 2-flop synchroniser, then a stable counter that updates the debounced level after DB_CYCLES consecutive equal samples. A press event is one cycle on the debounced 0->1 edge.
- Latency: raw edge to press event = 2 + DB_CYCLES cycles. Releases generate no event.
- Simultaneous press events in one cycle: one only, priority up > down > left > right; the rest are dropped.
- Reference direction r = queue tail if q_count>0, else dirc.
- Acceptance: a press of direction p is pushed when p != r, p != r^2'b01, and the queue is not full. Otherwise it is dropped silently.
- Exception: in IDLE the reversal rule is not applied, so the first press may be any direction other than dirc.
- FSM IDLE: tick ignored while the queue is empty. On a tick with q_count>0: pop head to dirc, moving<=1, go to RUN.
- FSM RUN: on tick with q_count>0, pop head into dirc. On tick with an empty queue, dirc holds.
- dirc changes only on the clock edge where tick=1. It is stable for the updater for the whole step.
- Push and pop in the same cycle:
  - Pop uses the old head; push evaluates r using pre-pop state; q_count is unchanged.
  - If the queue is full, the push is accepted because a slot frees that cycle.
- q_count saturates at QDEPTH and never underflows. Pointers wrap modulo QDEPTH.
- A tick held high for N cycles pops up to N entries. The step timer guarantees single-cycle pulses; this is not an error case.
- rstn asserted mid-operation: immediate return to the reset state, pending turns discarded, debouncers rearm (a button held through reset must be released and re-pressed).

Optional Feature:
- Macro: DIRC_PAUSE_EN.
- Defined:
  - Adds port btn_pause (input, 1, raw, same sync/debounce path) and output paused (1).
  - FSM gains state PAUSE. A pause press in RUN goes to PAUSE with paused=1. A pause press in PAUSE returns to RUN.
  - In PAUSE, tick is ignored and direction presses are dropped; the queue is retained.
  - paused resets to 0. A pause press in IDLE is ignored.
- Undefined: no btn_pause/paused ports; FSM is IDLE/RUN only.

Test Plan (DB_CYCLES=4, QDEPTH=2):
- Reset, press up for 10 cycles, then tick -> press event at cycle 6 after edge; q_count=1; after tick dirc=2'b10, moving=1, q_count=0.
- In RUN with dirc=01 (right): press left, then tick -> push rejected, q_count stays 0, dirc stays 01.
- dirc=01: press up, then press left before any tick -> both queued (q_count=2); first tick gives dirc=10, second tick gives dirc=00.
- Queue full (up, left queued from dirc=01): press down -> dropped; press down on the same edge as tick -> accepted; after tick dirc=10, q_count=2, tail=11.
- Glitch: btn_right high for 3 cycles then low -> no press event, q_count=0; assert rstn low with q_count=2 -> dirc=01, moving=0, q_count=0 asynchronously.
- DIRC_PAUSE_EN: in RUN press pause, apply 3 ticks with up queued -> paused=1, dirc unchanged, q_count=1; press pause again, then tick -> paused=0, dirc=10.
